// File: rtl/rx_ctrl.sv
// UART receive control: times one frame after a start edge, strobes the shift register mid-bit,
// checks the stop bit, then loads the buffer or raises a sticky framing error.
module rx_ctrl #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic sbc_clear,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + CLKS_PER_BIT / 2);
  localparam int BIT_W = $clog2(NUM_DATA_BITS + 2);
  localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(NUM_DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    RECEIVE    = 3'd2,
    STOP_CHECK = 3'd3,
    LOAD       = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_shift_strobe;
  logic             r_sbc_clear;
  logic             r_load_buffer;
  logic             r_framing_error;
  logic             r_rx_busy;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= IDLE;
      r_clk_cnt       <= '0;
      r_bit_cnt       <= '0;
      r_shift_strobe  <= 1'b0;
      r_sbc_clear     <= 1'b0;
      r_load_buffer   <= 1'b0;
      r_framing_error <= 1'b0;
      r_rx_busy       <= 1'b0;
    end else begin
      r_shift_strobe <= 1'b0;
      r_sbc_clear    <= 1'b0;
      r_load_buffer  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_bit_detected) begin
            r_state     <= CLEAR;
            r_sbc_clear <= 1'b1;
            r_rx_busy   <= 1'b1;
          end else begin
            r_rx_busy <= 1'b0;
          end
        end
        CLEAR: begin
          r_state         <= RECEIVE;
          r_framing_error <= 1'b0;
          r_clk_cnt       <= FIRST_LOAD;
          r_bit_cnt       <= '0;
        end
        RECEIVE: begin
          // Strobe is registered one cycle early so it is high exactly while clk_cnt is 0.
          if (r_clk_cnt != '0) begin
            r_clk_cnt      <= r_clk_cnt - CNT_ONE;
            r_shift_strobe <= (r_clk_cnt == CNT_ONE);
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_ONE;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= STOP_CHECK;
            end else begin
              r_clk_cnt <= BIT_LOAD;
            end
          end
        end
        STOP_CHECK: begin
          if (stop_bit) begin
            r_state       <= LOAD;
            r_load_buffer <= 1'b1;
          end else begin
            r_state         <= IDLE;
            r_framing_error <= 1'b1;
            r_rx_busy       <= 1'b0;
          end
        end
        LOAD: begin
          r_state   <= IDLE;
          r_rx_busy <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_rx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign shift_strobe  = r_shift_strobe;
  assign sbc_clear     = r_sbc_clear;
  assign load_buffer   = r_load_buffer;
  assign framing_error = r_framing_error;
  assign rx_busy       = r_rx_busy;

endmodule

// File: tb/tb_rx_ctrl.sv
// Bench for rx_ctrl: frame scenarios from a table, pulse events checked against a timed scoreboard.
module tb_rx_ctrl;

  logic clk = 1'b0;
  logic n_rst;
  logic start_bit_detected;
  logic stop_bit;
  logic shift_strobe, sbc_clear, load_buffer, framing_error, rx_busy;
  logic [4:0] outs;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  localparam int K_SBC = 0;
  localparam int K_STB = 1;
  localparam int K_LD  = 2;

  typedef struct {
    int kind;
    int t;
  } ev_t;
  ev_t q[$];

  typedef struct {
    logic stop;
    int   sp1;
    int   sp2;
    int   restart;
    logic exp_load;
    logic exp_fe;
  } vec_t;

  rx_ctrl #(.CLKS_PER_BIT(10), .NUM_DATA_BITS(8)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .start_bit_detected(start_bit_detected),
    .stop_bit          (stop_bit),
    .shift_strobe      (shift_strobe),
    .sbc_clear         (sbc_clear),
    .load_buffer       (load_buffer),
    .framing_error     (framing_error),
    .rx_busy           (rx_busy)
  );

  assign outs = {shift_strobe, sbc_clear, load_buffer, framing_error, rx_busy};

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Times are the last rising edge before the observing falling edge.
  task automatic push_frame(input int e, input logic with_load);
    q.push_back('{K_SBC, e});
    for (int k = 0; k < 9; k++) q.push_back('{K_STB, e + 15 + 10 * k});
    if (with_load) q.push_back('{K_LD, e + 97});
  endtask

  ev_t mon_e;
  int  mon_kind;
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].t < edge_n) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse: kind %0d expected at edge %0d not seen (now %0d)", mon_e.kind, mon_e.t, edge_n);
    end
    if (shift_strobe || sbc_clear || load_buffer) begin
      mon_kind = shift_strobe ? K_STB : (sbc_clear ? K_SBC : K_LD);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: kind %0d at edge %0d, none expected", mon_kind, edge_n);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.kind != mon_kind || mon_e.t != edge_n) begin
          errors++;
          $display("FAIL pulse_order: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                   mon_kind, edge_n, mon_e.kind, mon_e.t);
        end
      end
      chk("pulse_exclusive", 32'($countones({shift_strobe, sbc_clear, load_buffer})), 32'd1);
    end
  end

  task automatic run_frame(input vec_t v);
    int e;
    int t;
    @(negedge clk);
    e = edge_n + 1;
    start_bit_detected = 1'b1;
    stop_bit = ~v.stop;
    push_frame(e, v.exp_load);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      t = edge_n - e;
      start_bit_detected = (t + 1 == v.sp1) || (t + 1 == v.sp2) ||
                           (v.restart != 0 && t + 1 == v.restart);
      if (v.restart != 0 && t + 1 == v.restart) push_frame(e + v.restart, v.stop);
      stop_bit = (t >= 89) ? v.stop : ~v.stop;
      if (t == 0)  chk("busy_in_clear", 32'(rx_busy), 32'd1);
      if (t == 1)  chk("fe_cleared_after_sbc", 32'(framing_error), 32'd0);
      if (t == 50) chk("busy_mid_frame", 32'(rx_busy), 32'd1);
      if (t == 96) chk("busy_stop_check", 32'(rx_busy), 32'd1);
      if (t == 97) chk("busy_after_stop", 32'(rx_busy), 32'(v.exp_load));
      if (t == 98) chk("busy_dropped", 32'(rx_busy), 32'd0);
      if (t >= 97 && t < 127) chk("fe_held", 32'(framing_error), 32'(v.exp_fe));
    end
    start_bit_detected = 1'b0;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int e;
    tbl[0] = '{1'b1, 0,  0,  0,   1'b1, 1'b0};  // good frame
    tbl[1] = '{1'b0, 0,  0,  0,   1'b0, 1'b1};  // bad stop bit
    tbl[2] = '{1'b1, 0,  0,  0,   1'b1, 1'b0};  // recovery
    tbl[3] = '{1'b1, 40, 97, 100, 1'b1, 1'b0};  // spurious starts, then real restart
    tbl[4] = '{1'b0, 97, 0,  0,   1'b0, 1'b1};  // start during STOP_CHECK ignored
    tbl[5] = '{1'b1, 98, 0,  0,   1'b1, 1'b0};  // start during LOAD ignored

    n_rst = 1'b0;
    start_bit_detected = 1'b0;
    stop_bit = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("outs_in_reset", 32'(outs), 32'd0);
    end
    n_rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("outs_idle", 32'(outs), 32'd0);
    end

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Reset between 4th and 5th strobe aborts the frame silently.
    @(negedge clk);
    e = edge_n + 1;
    start_bit_detected = 1'b1;
    stop_bit = 1'b1;
    q.push_back('{K_SBC, e});
    for (int k = 0; k < 4; k++) q.push_back('{K_STB, e + 15 + 10 * k});
    @(negedge clk);
    start_bit_detected = 1'b0;
    while (edge_n - e < 49) @(negedge clk);
    chk("busy_before_abort", 32'(rx_busy), 32'd1);
    #2 n_rst = 1'b0;
    #1 chk("outs_async_reset", 32'(outs), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_queue_empty", 32'(q.size()), 32'd0);
    chk("abort_idle", 32'(outs), 32'd0);

    run_frame(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
- Receive control unit for the UART receive path; sits directly upstream of the 9-bit receive shift register and drives its shift strobe.
- Once the start-bit detector flags a falling edge on the serial line, the block does four things:
  - times one frame of NUM_DATA_BITS data bits plus one stop bit;
  - issues one single-cycle shift_strobe per bit, centred in the bit period;
  - checks the stop bit returned by the shift register;
  - either commands the receive buffer to load, or flags a framing error.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; legal range 2 and up.
NUM_DATA_BITS, 8, data bits per frame; strobes issued per frame = NUM_DATA_BITS+1 (data plus stop).

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous, active-low reset.
start_bit_detected  input  1  one-cycle pulse from the start-bit detector; serial line has just fallen.
stop_bit  input  1  stop-bit output of the receive shift register.
shift_strobe  output  1  one-cycle shift enable to the receive shift register.
sbc_clear  output  1  one-cycle pulse at frame start; clears downstream frame status.
load_buffer  output  1  one-cycle pulse; receive buffer captures packet_data.
framing_error  output  1  registered sticky flag; last frame had stop_bit = 0.
rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = IDLE; clk_cnt = 0; bit_cnt = 0.
  - All outputs 0, including framing_error.
  - Reset mid-frame aborts the frame: no strobe, no load, no error.
- Internal counters:
  - clk_cnt is a down-counter, width $clog2(CLKS_PER_BIT + CLKS_PER_BIT/2).
  - bit_cnt is an up-counter, width $clog2(NUM_DATA_BITS+2).
- IDLE:
  - Outputs low except a held framing_error.
  - start_bit_detected = 1 → CLEAR.
- CLEAR (exactly 1 cycle):
  - sbc_clear = 1.
  - framing_error cleared to 0 at the exit edge.
  - clk_cnt loaded with CLKS_PER_BIT + CLKS_PER_BIT/2 - 1, using integer division. Default load is 14.
  - bit_cnt loaded with 0.
  - Next state is RECEIVE.
- RECEIVE, each cycle:
  - If clk_cnt != 0: decrement clk_cnt, shift_strobe = 0.
  - If clk_cnt == 0: shift_strobe = 1 (Moore decode of state and clk_cnt), clk_cnt reloads CLKS_PER_BIT-1, bit_cnt increments.
  - When the strobe cycle is the (NUM_DATA_BITS+1)th strobe, next state is STOP_CHECK and there is no reload.
- Strobe timing (default parameters):
  - First strobe falls in the 15th RECEIVE cycle, i.e. 16 cycles after the edge that sampled start_bit_detected.
  - Subsequent strobes are every CLKS_PER_BIT cycles.
  - 9th strobe falls 96 cycles after the start edge.
- STOP_CHECK (1 cycle):
  - Samples stop_bit. The shift register has already absorbed the final strobe at the entry edge.
  - stop_bit = 1 → LOAD.
  - stop_bit = 0 → framing_error set to 1 at the exit edge; next state IDLE; load_buffer is never asserted.
- LOAD (1 cycle): load_buffer = 1; next state IDLE.
- framing_error holds until the next CLEAR state or reset; a good frame does not clear it any other way.
- start_bit_detected outside IDLE is ignored, including in LOAD and STOP_CHECK. It is not queued; the detector must re-pulse.
- shift_strobe, sbc_clear and load_buffer are mutually exclusive and never high for 2 consecutive cycles.
- Any undefined state encoding → IDLE.

Test Plan:
- Reset then idle: hold n_rst=0 for 2 cycles, then release with no start for 20 cycles → all outputs 0, rx_busy 0.
- Good frame, default parameters, stop_bit driven 1 from cycle 90:
  - start pulse at edge 0 → sbc_clear at cycle 1;
  - shift_strobe at cycles 16, 26, …, 96, exactly 9 pulses;
  - load_buffer at cycle 98; rx_busy drops at cycle 99; framing_error stays 0.
- Bad stop bit, stop_bit held 0 → same 9 strobes, load_buffer never asserts, framing_error = 1 from cycle 98 and held through 30 idle cycles.
- Error recovery: after a bad frame, send a good frame → framing_error returns to 0 the cycle after sbc_clear; load_buffer pulses normally.
- Reset mid-frame: assert n_rst low between the 4th and 5th strobes → outputs 0 immediately; after release there are no further strobes until a new start pulse.
- Spurious start: pulse start_bit_detected at cycles 40 and 97 of a frame → strobe timing unchanged, no second frame begins; a start pulse at cycle 100 begins a new frame with sbc_clear at 101.
